// File: rtl/div_if.sv
// Execute-stage to divider request/response bundle.
// The request is sampled on the accept edge (FREE, start=1, annul=0). The result is valid while o_ready=1 and stays stable until start drops.
interface div_if;
    logic        i_signed;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        i_start;
    logic        i_annul;
    logic [63:0] o_result;
    logic        o_ready;

    modport master (
        output i_signed, i_dividend, i_divisor, i_start, i_annul,
        input  o_result, o_ready
    );

    modport slave (
        input  i_signed, i_dividend, i_divisor, i_start, i_annul,
        output o_result, o_ready
    );
endinterface

// File: rtl/div.sv
// Iterative radix-2 restoring divider, 32-bit signed/unsigned, result {remainder, quotient}.
// dbg_state_o encodes the state as FREE=0, BYZERO=1, ON=2, END=3.
module div (
    input  logic       clk,
    input  logic       rst,
    div_if.slave       bus,
    output logic [1:0] dbg_state_o
);
    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] dvs_q, dvs_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [64:0] shifted;
    logic [32:0] trial;
    logic [64:0] step_w;
    logic [31:0] q_fix, r_fix;
    logic [31:0] dd_abs, dv_abs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FREE;
            cnt_q    <= 6'd0;
            work_q   <= 65'd0;
            dvs_q    <= 32'd0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        ready_d  = ready_q;

        dd_abs = (bus.i_signed && bus.i_dividend[31]) ? 32'd0 - bus.i_dividend : bus.i_dividend;
        dv_abs = (bus.i_signed && bus.i_divisor[31])  ? 32'd0 - bus.i_divisor  : bus.i_divisor;

        // Upper 33 bits hold the partial remainder, lower 32 shift out dividend and in quotient.
        shifted = work_q << 1;
        trial   = shifted[64:32] - {1'b0, dvs_q};
        step_w  = trial[32] ? shifted : {trial, shifted[31:1], 1'b1};
        q_fix   = qneg_q ? 32'd0 - step_w[31:0]  : step_w[31:0];
        r_fix   = rneg_q ? 32'd0 - step_w[63:32] : step_w[63:32];

        case (state_q)
            ST_FREE: begin
                if (bus.i_start && !bus.i_annul) begin
                    if (bus.i_divisor == 32'd0) begin
                        state_d = ST_BYZERO;
                    end else begin
                        dvs_d   = dv_abs;
                        work_d  = {33'd0, dd_abs};
                        qneg_d  = bus.i_signed & (bus.i_dividend[31] ^ bus.i_divisor[31]);
                        rneg_d  = bus.i_signed & bus.i_dividend[31];
                        cnt_d   = 6'd0;
                        state_d = ST_ON;
                    end
                end
            end
            ST_BYZERO: begin
                if (bus.i_annul) begin
                    state_d  = ST_FREE;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end else begin
                    work_d  = 65'd0;
                    state_d = ST_END;
                end
            end
            ST_ON: begin
                if (bus.i_annul) begin
                    state_d  = ST_FREE;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end else begin
                    work_d = step_w;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        // Sign-corrected result parks in the working register until END publishes it.
                        work_d  = {1'b0, r_fix, q_fix};
                        state_d = ST_END;
                    end
                end
            end
            ST_END: begin
                if (bus.i_annul || !bus.i_start) begin
                    state_d  = ST_FREE;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end else begin
                    ready_d  = 1'b1;
                    result_d = work_q[63:0];
                end
            end
            default: begin
                state_d = ST_FREE;
            end
        endcase
    end

    assign bus.o_result = result_q;
    assign bus.o_ready  = ready_q;
    assign dbg_state_o  = state_q;
endmodule
